// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver and transmitter: FSM state
// encoding, data width, frame layout constants and the parity rule.
// No ports (package).
// -----------------------------------------------------------------------------
package uart_pkg;

    // Number of data bits carried by one frame
    localparam int DATA_BITS = 8;

    // Frame layout: start, DATA_BITS data (LSB first), even parity, stop
    localparam int FRAME_BITS = 1 + DATA_BITS + 1 + 1;

    // Line level of the start and stop bits
    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

    // Smallest bit period that still leaves a distinct mid-bit sample point
    localparam int MIN_CLKS_PER_BIT = 4;

    // Receiver / transmitter frame-sequencing states
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

    // Even parity: the parity bit equals the XOR of all data bits
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        even_parity = ^data;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// -----------------------------------------------------------------------------
// uart_rx_if
// Bundles the serial input and the received-byte outputs of uart_rx.
//   rx          serial line (idles high)
//   data_out    last received byte
//   valid       one-cycle pulse when data_out and the error flags update
//   parity_err  parity bit did not match the data
//   frame_err   stop bit was sampled low
//   busy        receiver is inside a frame
// Modports: slave = the receiver, master = whoever drives the line and
// consumes the received bytes.
// -----------------------------------------------------------------------------
interface uart_rx_if;

    logic                           rx;
    logic [uart_pkg::DATA_BITS-1:0] data_out;
    logic                           valid;
    logic                           parity_err;
    logic                           frame_err;
    logic                           busy;

    modport slave (
        input  rx,
        output data_out,
        output valid,
        output parity_err,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        input  data_out,
        input  valid,
        input  parity_err,
        input  frame_err,
        input  busy
    );

endinterface

// File: rtl/uart_rx_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_sync
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge
// detector on the synchronized value. All flops reset to 1 (line idle) so
// that leaving reset never looks like a start edge on an idle line.
//   clk      system clock
//   rst_n    asynchronous active-low reset
//   rx       raw serial line
//   rx_s     synchronized serial line
//   rx_fall  high for one cycle when rx_s goes 1 -> 0
// -----------------------------------------------------------------------------
module uart_rx_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic rx,
    output logic rx_s,
    output logic rx_fall
);

    logic meta_r;
    logic sync_r;
    logic prev_r;

    // Synchronizer chain and one-cycle history of the synchronized line
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_r <= 1'b1;
            sync_r <= 1'b1;
            prev_r <= 1'b1;
        end else begin
            meta_r <= rx;
            sync_r <= meta_r;
            prev_r <= sync_r;
        end
    end

    assign rx_s    = sync_r;
    // Decoded only from flops, so it is glitch-free
    assign rx_fall = prev_r & ~sync_r;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// UART receiver: 1 start, 8 data (LSB first), 1 even parity, 1 stop bit.
// Bit timing comes only from CLKS_PER_BIT (minimum 4). The start bit is
// confirmed at its middle; every following bit is sampled one full bit
// period later, i.e. at its middle. One clock after the stop-bit sample the
// byte and both error flags are published together with a one-cycle valid.
// Ports:
//   clk    system clock (posedge)
//   rst_n  asynchronous active-low reset
//   bus    uart_rx_if.slave: rx in; data_out, valid, parity_err,
//          frame_err, busy out (all registered)
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic      clk,
    input  logic      rst_n,
    uart_rx_if.slave  bus
);

    localparam int TW = $clog2(CLKS_PER_BIT);

    // Sample points: middle of the start bit, then one full bit period apart
    localparam logic [TW-1:0] HALF_M1 = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] LAST    = TW'(CLKS_PER_BIT - 1);

    logic                 rx_s;
    logic                 rx_fall_s;

    uart_state_e          state_r;
    logic [TW-1:0]        timer_r;
    logic [2:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shift_r;
    logic                 parity_bit_r;
    logic                 stop_bit_r;
    logic                 done_r;
    logic [DATA_BITS-1:0] data_out_r;
    logic                 valid_r;
    logic                 parity_err_r;
    logic                 frame_err_r;
    logic                 busy_r;

    uart_rx_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .rx      (bus.rx),
        .rx_s    (rx_s),
        .rx_fall (rx_fall_s)
    );

    // Frame FSM, bit timer, shift register and registered result outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            timer_r      <= '0;
            bit_idx_r    <= 3'd0;
            shift_r      <= '0;
            parity_bit_r <= 1'b0;
            stop_bit_r   <= 1'b0;
            done_r       <= 1'b0;
            data_out_r   <= '0;
            valid_r      <= 1'b0;
            parity_err_r <= 1'b0;
            frame_err_r  <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            done_r  <= 1'b0;

            // Publish the frame one cycle after its stop-bit sample
            if (done_r) begin
                data_out_r   <= shift_r;
                parity_err_r <= (parity_bit_r != even_parity(shift_r));
                frame_err_r  <= (stop_bit_r != STOP_BIT);
                valid_r      <= 1'b1;
            end

            // Free-running bit timer; wraps at the end of each bit period
            if (timer_r == LAST) begin
                timer_r <= '0;
            end else begin
                timer_r <= timer_r + TW'(1);
            end

            case (state_r)
                IDLE: begin
                    timer_r <= '0;
                    // Edge-triggered: a line stuck low cannot start a frame
                    if (rx_fall_s) begin
                        state_r <= START;
                        busy_r  <= 1'b1;
                    end
                end
                START: begin
                    if (timer_r == HALF_M1) begin
                        timer_r <= '0;
                        if (rx_s == START_BIT) begin
                            state_r   <= DATA;
                            bit_idx_r <= 3'd0;
                        end else begin
                            // Glitch shorter than half a bit: drop it
                            state_r <= IDLE;
                            busy_r  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (timer_r == LAST) begin
                        // LSB arrives first, so shift in at the top
                        shift_r   <= {rx_s, shift_r[DATA_BITS-1:1]};
                        bit_idx_r <= bit_idx_r + 3'd1;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (timer_r == LAST) begin
                        parity_bit_r <= rx_s;
                        state_r      <= STOP;
                    end
                end
                STOP: begin
                    if (timer_r == LAST) begin
                        stop_bit_r <= rx_s;
                        done_r     <= 1'b1;
                        state_r    <= IDLE;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.data_out   = data_out_r;
    assign bus.valid      = valid_r;
    assign bus.parity_err = parity_err_r;
    assign bus.frame_err  = frame_err_r;
    assign bus.busy       = busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx with CLKS_PER_BIT = 16. A serial-line
// transmitter model drives frames; a monitor records every valid pulse.
// Expected results come from the frame rules: parity error when the sent
// parity bit differs from the XOR of the data, framing error when the stop
// bit is 0, valid about 10.5 bit times + 3 clk after the start edge.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CPB     = 16;
    localparam int LAT_NOM = (21 * CPB) / 2 + 3;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stp;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic       pe;
        logic       fe;
        int         cyc;
    } rx_ev_t;

    logic     clk = 1'b0;
    logic     rst_n = 1'b0;
    int       cyc = 0;
    int       start_cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    int       width_err = 0;
    logic     prev_valid = 1'b0;
    rx_ev_t   got_q[$];
    rx_ev_t   exp_q[$];

    uart_rx_if bus ();

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record each valid pulse and flag any pulse longer than one cycle
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            got_q.push_back('{bus.data_out, bus.parity_err, bus.frame_err, cyc});
            if (prev_valid) width_err++;
        end
        prev_valid = (bus.valid === 1'b1);
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bits(input int n);
        bus.rx = 1'b1;
        repeat (n * CPB) @(negedge clk);
    endtask

    // Serial transmitter model: start, 8 data LSB first, parity, stop
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp);
        logic [10:0] bits;
        bits = {stp, par, d, 1'b0};
        for (int i = 0; i < 11; i++) begin
            bus.rx = bits[i];
            if (i == 0) start_cyc = cyc;
            repeat (CPB) @(negedge clk);
        end
    endtask

    // Pop one received frame and compare it with the expectation
    task automatic expect_one(input string name, input logic [7:0] d,
                              input logic pe, input logic fe, input int sc);
        rx_ev_t ev;
        chk({name, " valid count"}, got_q.size(), 1);
        if (got_q.size() > 0) begin
            ev = got_q.pop_front();
            chk({name, " data"}, ev.data, d);
            chk({name, " parity_err"}, ev.pe, pe);
            chk({name, " frame_err"}, ev.fe, fe);
            vectors++;
            if (ev.cyc - sc < LAT_NOM - 3 || ev.cyc - sc > LAT_NOM + 4) begin
                miscompares++;
                $display("FAIL %s latency: got %0d clk, expected about %0d clk",
                         name, ev.cyc - sc, LAT_NOM);
            end
        end
        got_q.delete();
    endtask

    vec_t vecs[6];

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        int         sc;
        int         n;
        rx_ev_t     ev;
        rx_ev_t     ex;
        logic [7:0] lb[3];

        vecs[0] = '{8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        vecs[2] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[3] = '{8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
        vecs[4] = '{8'h80, 1'b1, 1'b1, 8'h80, 1'b0, 1'b0};
        vecs[5] = '{8'h7E, 1'b1, 1'b0, 8'h7E, 1'b1, 1'b1};

        // Reset state
        bus.rx = 1'b1;
        rst_n  = 1'b0;
        repeat (4) @(negedge clk);
        chk("reset data_out", bus.data_out, 8'h00);
        chk("reset valid", bus.valid, 1'b0);
        chk("reset parity_err", bus.parity_err, 1'b0);
        chk("reset frame_err", bus.frame_err, 1'b0);
        chk("reset busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        idle_bits(2);
        got_q.delete();

        // Table-driven single frames
        for (int i = 0; i < 6; i++) begin
            send_frame(vecs[i].data, vecs[i].par, vecs[i].stp);
            sc = start_cyc;
            idle_bits(2);
            expect_one($sformatf("vec%0d", i), vecs[i].exp_data,
                       vecs[i].exp_pe, vecs[i].exp_fe, sc);
            chk($sformatf("vec%0d busy after", i), bus.busy, 1'b0);
        end

        // Break: stop bit low, then line held low for 40 bit times
        send_frame(8'h3C, 1'b0, 1'b0);
        sc = start_cyc;
        bus.rx = 1'b0;
        repeat (40 * CPB) @(negedge clk);
        expect_one("break", 8'h3C, 1'b0, 1'b1, sc);
        idle_bits(2);
        chk("break no extra valid", got_q.size(), 0);
        send_frame(8'hA5, 1'b0, 1'b1);
        sc = start_cyc;
        idle_bits(2);
        expect_one("after break", 8'hA5, 1'b0, 1'b0, sc);

        // Short glitch: 4 clk low must be rejected as a false start
        bus.rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("glitch busy raised", bus.busy, 1'b1);
        bus.rx = 1'b1;
        n = 0;
        while (bus.busy === 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        chk("glitch busy dropped", bus.busy, 1'b0);
        idle_bits(2);
        chk("glitch no valid", got_q.size(), 0);

        // Reset in the middle of data bit 4, then a clean frame
        d = 8'hC3;
        for (int i = 0; i < 5; i++) begin
            bus.rx = (i == 0) ? 1'b0 : d[i-1];
            repeat (CPB) @(negedge clk);
        end
        bus.rx = d[4];
        repeat (CPB / 2) @(negedge clk);
        chk("pre-abort busy", bus.busy, 1'b1);
        rst_n  = 1'b0;
        bus.rx = 1'b1;
        @(negedge clk);
        chk("abort data_out", bus.data_out, 8'h00);
        chk("abort busy", bus.busy, 1'b0);
        chk("abort flags", {bus.parity_err, bus.frame_err, bus.valid}, 3'b000);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        idle_bits(3);
        chk("abort no valid", got_q.size(), 0);
        send_frame(8'h5A, 1'b0, 1'b1);
        sc = start_cyc;
        idle_bits(2);
        expect_one("after abort", 8'h5A, 1'b0, 1'b0, sc);

        // Loopback: back-to-back 0x00, 0xFF, 0x55 with correct parity
        lb[0] = 8'h00;
        lb[1] = 8'hFF;
        lb[2] = 8'h55;
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            send_frame(lb[i], ^lb[i], 1'b1);
            exp_q.push_back('{lb[i], 1'b0, 1'b0, 0});
        end

        // Random frames: mostly good, some bad parity or bad stop bit
        for (int i = 0; i < 24; i++) begin
            d = 8'($urandom);
            p = ($urandom_range(0, 3) != 0) ? ^d : ~(^d);
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s);
            exp_q.push_back('{d, p ^ (^d), ~s, 0});
            if (!s) idle_bits(1);
        end
        idle_bits(2);
        chk("stream frame count", got_q.size(), exp_q.size());
        n = 0;
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            ev = got_q.pop_front();
            ex = exp_q.pop_front();
            chk($sformatf("stream%0d data", n), ev.data, ex.data);
            chk($sformatf("stream%0d parity_err", n), ev.pe, ex.pe);
            chk($sformatf("stream%0d frame_err", n), ev.fe, ex.fe);
            n++;
        end

        chk("valid pulse width", width_err, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 434, clk cycles per serial bit (50 MHz / 115200); legal minimum 4.
REQ-002 clk  input  1  system clock; all sequential logic on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 rx  input  1  serial line, asynchronous to clk, idles high.
REQ-005 data_out  output  8  last received byte, held until next frame completes.
REQ-006 valid  output  1  one-cycle pulse: data_out and error flags updated.
REQ-007 parity_err  output  1  registered with valid: received parity bit != XOR of data bits.
REQ-008 frame_err  output  1  registered with valid: stop bit sampled low.
REQ-009 busy  output  1  high whenever state != IDLE.

Function
REQ-010 Frame SHALL be: 1 start (0), 8 data LSB first, 1 even-parity bit (= XOR of data), 1 stop (1); matches uart_tx output.
REQ-011 rx SHALL pass a 2-flop synchronizer (flops reset to 1) before any use; all references below are to the synchronized rx_s.
REQ-012 States SHALL be IDLE, START, DATA, PARITY, STOP.
REQ-013 IDLE: on rx_s falling edge (previous 1, current 0) -> START, bit-timer cleared; a line held low never retriggers.
REQ-014 START: at timer = CLKS_PER_BIT/2 - 1 sample rx_s; 0 -> DATA with timer cleared; 1 -> IDLE (false start, no valid).
REQ-015 DATA: sample rx_s every CLKS_PER_BIT cycles (mid-bit), shift into bit 7 of shift register moving right; after 8th sample -> PARITY.
REQ-016 Bit index counter SHALL be 3 bits, 0..7, cleared on entry to DATA.
REQ-017 PARITY: sample once at mid-bit, store, -> STOP.
REQ-018 STOP: sample at mid-bit; next cycle data_out <= shift register, parity_err and frame_err computed from samples, valid = 1 for exactly one cycle, state -> IDLE.
REQ-019 Latency: valid SHALL assert 1 clk after the stop-bit mid sample, i.e. ~10.5 bit times + 3 clk (synchronizer + register) after the start falling edge on rx.
REQ-020 Error frames SHALL still deliver data_out and valid; flags indicate error; flags cleared/updated only on the next valid.
REQ-021 Frame error (stop = 0): return to IDLE; next frame requires a new falling edge, so a break condition produces exactly one valid.
REQ-022 Back-to-back frames with a single stop bit SHALL be received without loss (IDLE reached before next start edge).
REQ-023 Bit timer SHALL be $clog2(CLKS_PER_BIT) bits, wraps to 0 at CLKS_PER_BIT-1; no overflow path.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, data_out 0, valid 0, parity_err 0, frame_err 0, busy 0, timers/counters 0, synchronizer flops 1.
REQ-025 Reset mid-frame SHALL abandon the frame with no valid; after release the block waits for a fresh falling edge.

Structure
REQ-026 Shared package uart_pkg SHALL hold state encodings, DATA_BITS = 8, the frame layout constants and the parity rule, shared with uart_tx.
REQ-027 One sub-module is natural: uart_rx_sync (2-flop synchronizer + falling-edge detect); timer and FSM stay in uart_rx.
REQ-028 No dependency on BaudGenerator; timing derives solely from CLKS_PER_BIT.

Verification (bench uses CLKS_PER_BIT = 16)
REQ-029 Send 0xA5, parity 0, stop 1 -> data_out = 0xA5, single-cycle valid, parity_err = 0, frame_err = 0, busy low afterwards.
REQ-030 Send 0x01 with parity bit 0 -> data_out = 0x01, valid, parity_err = 1, frame_err = 0.
REQ-031 Send 0x3C with stop bit 0 then hold rx low 40 bit times -> exactly one valid, frame_err = 1, no further valid until rx rises and falls.
REQ-032 Drive rx low for 4 clk then high -> no valid, state returns to IDLE, busy drops within 8 clk.
REQ-033 Assert rst_n low during DATA bit 4, release, then send 0x5A -> no valid for aborted frame, outputs 0 during reset, then 0x5A received cleanly.
REQ-034 uart_tx loopback, back-to-back 0x00, 0xFF, 0x55 -> three valids, matching bytes, no error flags.
